stream_to_simple_write: RTL



---
 rtl/stream_to_simple_write_if.sv | 50 +++++
 rtl/stream_to_simple_write.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/stream_to_simple_write_if.sv
// Purpose: bundles the command, stream and simple-write handshake signals of
//          stream_to_simple_write into one interface.
// Modports:
//   master - the converter side: takes commands and stream words, drives m_w*.
//   slave  - the environment side: issues commands, feeds words, accepts m_w*.
// Signals:
//   cmd_valid_i/cmd_ready_o/cmd_addr_i/cmd_len_i : write command handshake
//   s_valid_i/s_ready_o/s_data_i                 : 32-bit data word stream
//   m_wvalid_o/m_wready_i/m_waddr_o/m_wdata_o/
//   m_wstrb_o/m_wlen_o/m_wlast_i                 : simple write interface
interface stream_to_simple_write_if #(
  parameter int unsigned AXI_ADDR_W = 32,
  parameter int unsigned AXI_DATA_W = 32,
  parameter int unsigned LEN_W      = 8
);
  logic                    cmd_valid_i;
  logic                    cmd_ready_o;
  logic [AXI_ADDR_W-1:0]   cmd_addr_i;
  logic [31:0]             cmd_len_i;

  logic                    s_valid_i;
  logic                    s_ready_o;
  logic [AXI_DATA_W-1:0]   s_data_i;

  logic                    m_wvalid_o;
  logic                    m_wready_i;
  logic [AXI_ADDR_W-1:0]   m_waddr_o;
  logic [AXI_DATA_W-1:0]   m_wdata_o;
  logic [AXI_DATA_W/8-1:0] m_wstrb_o;
  logic [LEN_W-1:0]        m_wlen_o;
  logic                    m_wlast_i;

  modport master (
    input  cmd_valid_i, cmd_addr_i, cmd_len_i,
    output cmd_ready_o,
    input  s_valid_i, s_data_i,
    output s_ready_o,
    output m_wvalid_o, m_waddr_o, m_wdata_o, m_wstrb_o, m_wlen_o,
    input  m_wready_i, m_wlast_i
  );

  modport slave (
    output cmd_valid_i, cmd_addr_i, cmd_len_i,
    input  cmd_ready_o,
    output s_valid_i, s_data_i,
    input  s_ready_o,
    input  m_wvalid_o, m_waddr_o, m_wdata_o, m_wstrb_o, m_wlen_o,
    output m_wready_i, m_wlast_i
  );
endinterface

// File: rtl/stream_to_simple_write.sv
// Purpose: splits a (base address, byte length) write command into word-aligned
//          chunks of at most MAX_CHUNK_BYTES and plays the buffered 32-bit data
//          stream out on the simple write interface, one chunk at a time.
// Ports:
//   clk_i   - clock
//   rst_i   - synchronous active-high reset
//   bus     - command, stream and simple-write handshakes (master modport)
//   busy_o  - command in progress
//   done_o  - one-cycle pulse when a command completes
//   err_o   - sticky; m_wlast_i disagreed with the internal beat count
module stream_to_simple_write #(
  parameter int unsigned AXI_ADDR_W      = 32,
  parameter int unsigned AXI_DATA_W      = 32,
  parameter int unsigned LEN_W           = 8,
  parameter int unsigned MAX_CHUNK_BYTES = 252,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  stream_to_simple_write_if.master bus,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);

  localparam int unsigned STRB_W = AXI_DATA_W / 8;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned LENX_W = LEN_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_XFER, S_GAP} state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [AXI_ADDR_W-1:0] r_cur_addr;
  logic [31:0]           r_remaining;
  logic [31:0]           r_words_total;
  logic [31:0]           r_words_acc;
  logic [AXI_ADDR_W-1:0] r_waddr;
  logic [LEN_W-1:0]      r_wlen;
  logic [LEN_W-1:0]      r_beats;
  logic [LEN_W-1:0]      r_beat_cnt;
  logic                  r_done;
  logic                  r_err;

  logic [AXI_DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  logic                  w_cmd_ready;
  logic                  w_busy;
  logic                  w_s_ready;
  logic                  w_wvalid;
  logic [STRB_W-1:0]     w_wstrb;
  logic                  w_cmd_fire;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_last_beat;
  logic                  w_fifo_full;
  logic [LEN_W-1:0]      w_chunk;
  logic [LEN_W-1:0]      w_beats;
  logic [31:0]           w_words_total;

  assign w_cmd_fire    = bus.cmd_valid_i && w_cmd_ready;
  assign w_push        = bus.s_valid_i && w_s_ready;
  assign w_pop         = w_wvalid && bus.m_wready_i;
  assign w_fifo_full   = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_last_beat   = (r_beat_cnt == r_beats - LEN_W'(1));
  assign w_words_total = 32'((33'(bus.cmd_len_i) + 33'd3) >> 2);
  assign w_chunk       = (r_remaining < 32'(MAX_CHUNK_BYTES)) ? LEN_W'(r_remaining)
                                                              : LEN_W'(MAX_CHUNK_BYTES);
  assign w_beats       = LEN_W'((LENX_W'(w_chunk) + LENX_W'(3)) >> 2);

  assign bus.cmd_ready_o = w_cmd_ready;
  assign bus.s_ready_o   = w_s_ready;
  assign bus.m_wvalid_o  = w_wvalid;
  assign bus.m_waddr_o   = r_waddr;
  assign bus.m_wlen_o    = r_wlen;
  assign bus.m_wstrb_o   = w_wstrb;
  assign bus.m_wdata_o   = r_mem[r_rd_ptr];
  assign busy_o          = w_busy;
  assign done_o          = r_done;
  assign err_o           = r_err;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; a zero-length command never leaves IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_cmd_fire && (bus.cmd_len_i != 32'd0)) w_state_nxt = S_SETUP;
      S_SETUP: w_state_nxt = S_XFER;
      S_XFER:  if (w_pop && w_last_beat) w_state_nxt = S_GAP;
      S_GAP:   w_state_nxt = (r_remaining == 32'd0) ? S_IDLE : S_SETUP;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode; the partial strobe can only occur on the final chunk since
  // every earlier chunk is a full MAX_CHUNK_BYTES (a multiple of 4)
  always_comb begin
    w_cmd_ready = 1'b0;
    w_busy      = 1'b0;
    w_wvalid    = 1'b0;
    w_wstrb     = '0;
    case (r_state)
      S_IDLE:  w_cmd_ready = 1'b1;
      S_SETUP: w_busy = 1'b1;
      S_GAP:   w_busy = 1'b1;
      S_XFER: begin
        w_busy   = 1'b1;
        w_wvalid = (r_count != '0);
        w_wstrb  = '1;
        if (w_last_beat) begin
          case (r_wlen[1:0])
            2'd1:    w_wstrb = STRB_W'(4'h1);
            2'd2:    w_wstrb = STRB_W'(4'h3);
            2'd3:    w_wstrb = STRB_W'(4'h7);
            default: w_wstrb = '1;
          endcase
        end
      end
      default: ;
    endcase
    w_s_ready = w_busy && !w_fifo_full && (r_words_acc < r_words_total);
  end

  // Command / chunk datapath and status flags
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cur_addr    <= '0;
      r_remaining   <= '0;
      r_words_total <= '0;
      r_words_acc   <= '0;
      r_waddr       <= '0;
      r_wlen        <= '0;
      r_beats       <= '0;
      r_beat_cnt    <= '0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_push) r_words_acc <= r_words_acc + 32'd1;
      case (r_state)
        S_IDLE: begin
          if (w_cmd_fire) begin
            r_cur_addr    <= bus.cmd_addr_i;
            r_remaining   <= bus.cmd_len_i;
            r_words_total <= w_words_total;
            r_words_acc   <= '0;
            if (bus.cmd_len_i == 32'd0) r_done <= 1'b1;
          end
        end
        S_SETUP: begin
          r_waddr    <= r_cur_addr;
          r_wlen     <= w_chunk;
          r_beats    <= w_beats;
          r_beat_cnt <= '0;
        end
        S_XFER: begin
          if (w_pop) begin
            r_beat_cnt <= r_beat_cnt + LEN_W'(1);
            // m_wlast_i is only checked; the internal count ends the chunk
            if (w_last_beat) begin
              r_cur_addr  <= r_cur_addr + AXI_ADDR_W'(r_wlen);
              r_remaining <= r_remaining - 32'(r_wlen);
              if (!bus.m_wlast_i) r_err <= 1'b1;
            end else if (bus.m_wlast_i) begin
              r_err <= 1'b1;
            end
          end
        end
        S_GAP: if (r_remaining == 32'd0) r_done <= 1'b1;
        default: ;
      endcase
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // FIFO storage
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.s_data_i;
  end

endmodule
